// File: rtl/mul_seq_ctrl.sv
// Digit-serial packed-BCD multiply (NDIG digits x 1 digit) built around one single-digit mul instance.
// Latency NDIG+1 cycles start->done (1 cycle for a non-BCD request); start outside IDLE is dropped, never queued.

module mul (
    input  logic [3:0] dig1,
    input  logic [3:0] dig2,
    output logic [3:0] prod
);
    logic [7:0] full;

    assign full = {4'd0, dig1} * {4'd0, dig2};
    assign prod = 4'(full % 8'd10);
endmodule

module mul_seq_ctrl #(
    parameter int NDIG = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [4*NDIG-1:0]       a,
    input  logic [3:0]              b,
    output logic                    busy,
    output logic                    done,
    output logic [4*(NDIG+1)-1:0]   result,
    output logic                    err
);
    localparam int IW = $clog2(NDIG);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [4*NDIG-1:0]       a_q, a_nxt;
    logic [3:0]              b_q, b_nxt;
    logic [IW-1:0]           idx, idx_nxt;
    logic [3:0]              carry, carry_nxt;
    logic [4*(NDIG+1)-1:0]   res_nxt;
    logic                    err_nxt;
    logic [3:0]              dig_a;
    logic [3:0]              units;
    logic [3:0]              tens;
    logic [4:0]              sum;

    function automatic logic any_bad(input logic [4*NDIG-1:0] av, input logic [3:0] bv);
        logic bad;
        bad = (bv > 4'd9);
        for (int k = 0; k < NDIG; k++) begin
            if (av[4*k +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Tens digit of x*y for BCD inputs; at most 8 (9*9 = 81).
    function automatic logic [3:0] tens_of(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] p;
        logic [3:0] t;
        p = {4'd0, x} * {4'd0, y};
        t = 4'd0;
        for (int k = 1; k <= 8; k++) begin
            if (p >= 8'(k * 10)) t = 4'(k);
        end
        return t;
    endfunction

    // The shared digit multiplier only ever sees latched operands.
    assign dig_a = a_q[4*int'(idx) +: 4];

    mul u_mul (
        .dig1 (dig_a),
        .dig2 (b_q),
        .prod (units)
    );

    assign tens = tens_of(dig_a, b_q);
    assign sum  = {1'b0, units} + {1'b0, carry};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            idx    <= '0;
            carry  <= '0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            a_q    <= a_nxt;
            b_q    <= b_nxt;
            idx    <= idx_nxt;
            carry  <= carry_nxt;
            result <= res_nxt;
            err    <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        a_nxt     = a_q;
        b_nxt     = b_q;
        idx_nxt   = idx;
        carry_nxt = carry;
        res_nxt   = result;
        err_nxt   = err;
        busy      = 1'b0;
        done      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    a_nxt     = a;
                    b_nxt     = b;
                    res_nxt   = '0;
                    idx_nxt   = '0;
                    carry_nxt = '0;
                    if (any_bad(a, b)) begin
                        err_nxt   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        err_nxt   = 1'b0;
                        state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                busy = 1'b1;
                if (sum >= 5'd10) begin
                    res_nxt[4*int'(idx) +: 4] = 4'(sum - 5'd10);
                    carry_nxt                 = tens + 4'd1;
                end else begin
                    res_nxt[4*int'(idx) +: 4] = sum[3:0];
                    carry_nxt                 = tens;
                end
                if (idx == IW'(NDIG - 1)) begin
                    res_nxt[4*NDIG +: 4] = carry_nxt;
                    state_nxt            = DONE;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl (NDIG=4) with a scoreboard of decimal-model products.
module tb_mul_seq_ctrl;
    localparam int NDIG = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [3:0]  b;
    logic        busy;
    logic        done;
    logic [19:0] result;
    logic        err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [20:0] sb[$];

    mul_seq_ctrl #(.NDIG(NDIG)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err)
    );

    always #5 clk = ~clk;

    // Reference: decode BCD to an integer, multiply, re-encode as 5 BCD digits.
    function automatic logic [20:0] ref_mul(input logic [15:0] av, input logic [3:0] bv);
        int         x = 0;
        int         p;
        bit         bad = 0;
        logic [19:0] r = '0;
        for (int k = 3; k >= 0; k--) begin
            if (av[4*k +: 4] > 4'd9) bad = 1;
            x = x * 10 + int'(av[4*k +: 4]);
        end
        if (bv > 4'd9) bad = 1;
        if (bad) return {1'b1, 20'h0};
        p = x * int'(bv);
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'(p % 10);
            p = p / 10;
        end
        return {1'b0, r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic [15:0] av, input logic [3:0] bv, input bit keep);
        sb.push_back(ref_mul(av, bv));
        a     = av;
        b     = bv;
        start = 1'b1;
        cyc   = 0;
        tick();
        if (!keep) start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        logic [20:0] e;
        while (done !== 1'b1 && cyc < 30) begin
            chk({tag, "/busy_run"}, 32'(busy), 32'd1);
            tick();
        end
        chk({tag, "/latency"}, 32'(cyc), 32'(exp_lat));
        e = (sb.size() != 0) ? sb.pop_front() : 21'h1FFFFF;
        chk({tag, "/busy_done"}, 32'(busy), 32'd1);
        chk({tag, "/result"}, 32'(result), 32'(e[19:0]));
        chk({tag, "/err"}, 32'(err), 32'(e[20]));
        tick();
        chk({tag, "/done_pulse"}, 32'(done), 32'd0);
        chk({tag, "/busy_idle"}, 32'(busy), 32'd0);
        chk({tag, "/result_hold"}, 32'(result), 32'(e[19:0]));
        chk({tag, "/err_hold"}, 32'(err), 32'(e[20]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset wins over a simultaneous start.
        rst   = 1'b1;
        start = 1'b1;
        a     = 16'h1234;
        b     = 4'h7;
        repeat (3) tick();
        chk("reset/busy", 32'(busy), 32'd0);
        chk("reset/done", 32'(done), 32'd0);
        chk("reset/result", 32'(result), 32'd0);
        chk("reset/err", 32'(err), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        chk("idle/busy", 32'(busy), 32'd0);
        chk("idle/done", 32'(done), 32'd0);

        issue(16'h1234, 4'h7, 1'b0);  wait_done("basic", 5);
        issue(16'h12A4, 4'h3, 1'b0);  wait_done("bad_a", 1);
        issue(16'h9999, 4'h9, 1'b0);  wait_done("carry9", 5);
        issue(16'h1234, 4'hC, 1'b0);  wait_done("bad_b", 1);
        issue(16'h9999, 4'h1, 1'b0);  wait_done("times1", 5);
        issue(16'h0000, 4'h5, 1'b0);  wait_done("zero_a", 5);
        issue(16'h4321, 4'h0, 1'b0);  wait_done("zero_b", 5);

        // Second start sampled at cycle 2 must be dropped.
        issue(16'h0567, 4'h3, 1'b0);
        tick();
        a     = 16'h9999;
        b     = 4'h9;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("busy_ign", 5);
        issue(16'h2468, 4'h5, 1'b0);  wait_done("after_ign", 5);

        // start held high: one IDLE cycle between operations.
        issue(16'h0102, 4'h4, 1'b1);  wait_done("held1", 5);
        issue(16'h0102, 4'h4, 1'b0);  wait_done("held2", 5);

        // Reset sampled at cycle 3 aborts the operation.
        issue(16'h5678, 4'h6, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("abort/busy", 32'(busy), 32'd0);
        chk("abort/done", 32'(done), 32'd0);
        chk("abort/result", 32'(result), 32'd0);
        rst = 1'b0;
        sb.delete();
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("abort/no_done", 32'(done), 32'd0);
        end
        chk("abort/result_kept", 32'(result), 32'd0);
        issue(16'h8765, 4'h8, 1'b0);  wait_done("post_abort", 5);

        chk("sb/empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequential controller that multiplies an NDIG-digit packed-BCD operand by a single BCD digit. It reuses one instance of the existing single-digit `mul` block, which returns the units digit of `dig1*dig2`, and processes one digit per clock, LSB first. The block adds an internal tens-digit table and a BCD carry chain around that instance. It sits between the calculator's operand registers and its result display, and drives a start/done handshake towards the calculator sequencer.

## Interface

Parameters:

- `NDIG`, default 4: number of BCD digits in operand `a`; legal range 2–8.

Ports:

- `clk`, input, 1 bit: single clock; all state changes on its rising edge.
- `rst`, input, 1 bit: reset. Synchronous and active-high.
- `start`, input, 1 bit: request. Sampled only in IDLE.
- `a`, input, 4*NDIG bits: multiplicand, packed BCD, digit 0 in bits [3:0].
- `b`, input, 4 bits: multiplier, one BCD digit.
- `busy`, output, 1 bit: high from the cycle after an accepted start until the cycle after `done`.
- `done`, output, 1 bit: one-cycle pulse; `result` and `err` are valid from this cycle.
- `result`, output, 4*(NDIG+1) bits: packed-BCD product, digit 0 in bits [3:0].
- `err`, output, 1 bit: the last accepted request contained a non-BCD digit (value > 9).

## Operation

- States: IDLE, CALC, DONE.
- **IDLE**
  - When `start`=1, latch `a` and `b`.
  - Check every digit of `a` and `b`. If any digit is > 9, set `err`=1, clear `result` to 0 and go to DONE.
  - Otherwise clear `err`, clear `result`, set digit index `i`=0 and carry `c`=0, then go to CALC.
- **CALC** (one digit per cycle)
  - `u` = `mul(a[i], b)`, the units digit of the product.
  - `t` = tens digit of `a[i]*b`, taken from the internal table (0–8).
  - `s` = `u` + `c`, range 0–17.
  - If `s` ≥ 10: `result` digit `i` = `s`−10 and `c` = `t`+1. Otherwise: `result` digit `i` = `s` and `c` = `t`.
  - `c` never exceeds 9.
  - When `i` = NDIG−1: write `c` into `result` digit NDIG and go to DONE. Otherwise increment `i`.
- **DONE**
  - `done`=1 for exactly this cycle, then go to IDLE.
- `start` in CALC or DONE is ignored. It is not queued.
- `result` and `err` hold their value until the next accepted start.
- The datapath is digit-serial only. Only one `mul` instance is used and it is fed from the latched operands, never from the live `a`/`b`.

## Timing

- Reset (`rst`=1 at a rising edge) forces:
  - state = IDLE
  - `busy`=0, `done`=0, `err`=0
  - `result`=0
  - `i`=0, `c`=0
  - latched operands = 0
- Reset takes priority over `start` in the same cycle.
- Reset during CALC aborts the operation. No `done` pulse is produced.
- Let cycle 0 be the edge at which `start` is sampled in IDLE. For a valid request:
  - CALC occupies cycles 1..NDIG.
  - `done`=1 in cycle NDIG+1.
  - Latency from start to done is NDIG+1 cycles.
- For an invalid request, `done`=1 and `err`=1 in cycle 1.
- `busy`=1 for cycles 1..NDIG+1, and 0 in IDLE.
- A new `start` may be accepted in cycle NDIG+2 at the earliest. Maximum throughput is one operation per NDIG+2 cycles.
- `start` held high continuously gives back-to-back operations, each separated by one IDLE cycle.
- `result` digits may change during CALC. Consumers sample `result` only when `done`=1 or later.

## Test plan

- **Basic product:** NDIG=4, `a`=16'h1234, `b`=4'h7, pulse `start` → `done` at cycle 5 with `result`=20'h08638, `err`=0, `busy` high for cycles 1–5.
- **Maximum carry chain:** `a`=16'h9999, `b`=4'h9 → `result`=20'h89991 at `done`. Also `a`=16'h9999, `b`=4'h1 → `result`=20'h09999.
- **Zeros:** `a`=16'h0000, `b`=4'h5 → `result`=0. `a`=16'h4321, `b`=4'h0 → `result`=0. Both with `err`=0.
- **Invalid digit:** `a`=16'h12A4, `b`=4'h3 → `done` at cycle 1 with `err`=1 and `result`=0. `b`=4'hC gives the same response.
- **Start while busy:** second `start` pulse at cycle 2 with different operands → ignored. A single `done` at cycle 5 carries the first product. A new `start` at cycle 6 is accepted and completes at cycle 11.
- **Reset mid-operation:** assert `rst` at cycle 3 of an operation → the next cycle shows `busy`=0, `done`=0 and `result`=0. No `done` pulse follows. A subsequent start completes normally.
